// File: rtl/conbus_arb_wdt.sv
// conbus_arb_wdt: round-robin grant for the shared conbus plus a stall watchdog that forces a one-cycle ack.
// Optional macro CONBUS_ARB_PRIO0_EN: on handover, master 0 wins if requesting; others stay round-robin.
module conbus_arb_wdt #(
   parameter int N_MASTERS  = 7,
   parameter int TMO_W      = 8,
   parameter int TMO_CYCLES = 255
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [N_MASTERS-1:0] req,
   input  logic                 bus_stb,
   input  logic                 bus_ack,
   input  logic                 tmo_clr,
   output logic [N_MASTERS-1:0] gnt,
   output logic                 tmo_ack,
   output logic                 tmo_err,
   output logic [2:0]           tmo_master
);
   localparam int IW = $clog2(N_MASTERS);
   localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYCLES - 1);
   localparam logic [TMO_W-1:0] SAT = TMO_W'(TMO_CYCLES);
   localparam logic [N_MASTERS-1:0] ONE = N_MASTERS'(1);

   logic [N_MASTERS-1:0] gnt_nxt;
   logic [2:0]           cur;
   logic [IW-1:0]        idx;
   logic [TMO_W-1:0]     cnt;
   logic                 chg, trig;

   // index of the current owner, decoded from the one-hot grant
   always_comb begin
      cur = '0;
      for (int i = 0; i < N_MASTERS; i++) if (gnt[i]) cur = 3'(i);
   end

   // hold while the owner requests; otherwise nearest requester after cur (descending scan so nearest wins), else park
   always_comb begin
      gnt_nxt = gnt;
      idx = '0;
      if ((req & gnt) == '0) begin
         for (int k = N_MASTERS - 1; k > 0; k--) begin
            idx = IW'((int'(cur) + k) % N_MASTERS);
            if (req[idx]) gnt_nxt = ONE << idx;
         end
`ifdef CONBUS_ARB_PRIO0_EN
         if (req[0]) gnt_nxt = ONE;
`else
`endif
      end
   end

   assign chg  = gnt_nxt != gnt;
   assign trig = bus_stb & ~bus_ack & ~tmo_ack & (cnt == LAST);

   // grant register, watchdog stall counter and sticky timeout status (set beats clear)
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         gnt        <= ONE;
         cnt        <= '0;
         tmo_ack    <= 1'b0;
         tmo_err    <= 1'b0;
         tmo_master <= '0;
      end else begin
         gnt        <= gnt_nxt;
         cnt        <= (!bus_stb || bus_ack || tmo_ack || chg) ? '0 : (cnt == SAT) ? cnt : cnt + 1'b1;
         tmo_ack    <= trig;
         tmo_err    <= trig | (tmo_err & ~tmo_clr);
         tmo_master <= trig ? cur : tmo_clr ? 3'd0 : tmo_master;
      end
   end
endmodule

// File: tb/tb_conbus_arb_wdt.sv
// tb_conbus_arb_wdt: directed self-checking bench for conbus_arb_wdt with TMO_CYCLES=4.
module tb_conbus_arb_wdt;
   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [6:0] req = '0;
   logic       bus_stb = 1'b0, bus_ack = 1'b0, tmo_clr = 1'b0;
   logic [6:0] gnt;
   logic       tmo_ack, tmo_err;
   logic [2:0] tmo_master;
   int         errors = 0, checks = 0;

   conbus_arb_wdt #(.N_MASTERS(7), .TMO_W(8), .TMO_CYCLES(4)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .bus_stb(bus_stb), .bus_ack(bus_ack),
      .tmo_clr(tmo_clr), .gnt(gnt), .tmo_ack(tmo_ack), .tmo_err(tmo_err), .tmo_master(tmo_master)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic step(input int n = 1);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic chk_gnt(input string name, input logic [6:0] exp);
      checks++;
      if (gnt !== exp) begin
         errors++;
         $display("FAIL %s: gnt=%h expected %h", name, gnt, exp);
      end
   endtask

   task automatic chk_tmo(input string name, input logic a, input logic e, input logic [2:0] m);
      checks++;
      if ({tmo_ack, tmo_err, tmo_master} !== {a, e, m}) begin
         errors++;
         $display("FAIL %s: ack/err/master=%b/%b/%0d expected %b/%b/%0d", name, tmo_ack, tmo_err, tmo_master, a, e, m);
      end
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      step(2);
      chk_gnt("reset_gnt", 7'h01);
      chk_tmo("reset_tmo", 1'b0, 1'b0, 3'd0);
      sys_rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_gnt("reset_park", 7'h01);
      end
   endtask

   task automatic test_rotate();
      req = 7'h0D; step(); chk_gnt("rot_hold0", 7'h01);
      req = 7'h0C; step(); chk_gnt("rot_to2", 7'h04);
      req = 7'h08; step(); chk_gnt("rot_to3", 7'h08);
      req = 7'h00; step(); chk_gnt("rot_park3", 7'h08);
      step(); chk_gnt("rot_park3b", 7'h08);
   endtask

   task automatic test_wrap();
      req = 7'h40; step(); chk_gnt("wrap_to6", 7'h40);
      req = 7'h41; step(); chk_gnt("wrap_hold6", 7'h40);
      req = 7'h01; step(); chk_gnt("wrap_to0", 7'h01);
      req = 7'h00; step();
   endtask

   task automatic test_back_to_back();
      req = 7'h04; step(); chk_gnt("b2b_to2", 7'h04);
      req = 7'h06; step(); chk_gnt("b2b_hold2", 7'h04);
      req = 7'h02; step(); chk_gnt("b2b_drop_rot", 7'h02);
      req = 7'h06; step(); chk_gnt("b2b_hold1", 7'h02);
      req = 7'h04; step(); chk_gnt("b2b_back2", 7'h04);
   endtask

   task automatic test_timeout();
      bus_stb = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk_tmo("tmo_wait", 1'b0, 1'b0, 3'd0);
      end
      step(); chk_tmo("tmo_fire", 1'b1, 1'b1, 3'd2);
      step(); chk_tmo("tmo_single", 1'b0, 1'b1, 3'd2);
      bus_stb = 1'b0;
      step(2); chk_tmo("tmo_sticky", 1'b0, 1'b1, 3'd2);
      tmo_clr = 1'b1; step(); tmo_clr = 1'b0;
      chk_tmo("tmo_clr", 1'b0, 1'b0, 3'd0);
      bus_stb = 1'b1;
      step(3);
      tmo_clr = 1'b1; step(); tmo_clr = 1'b0;
      chk_tmo("tmo_set_wins", 1'b1, 1'b1, 3'd2);
      bus_stb = 1'b0;
      tmo_clr = 1'b1; step(); tmo_clr = 1'b0;
      chk_tmo("tmo_clr2", 1'b0, 1'b0, 3'd0);
   endtask

   task automatic test_ack_wins();
      bus_stb = 1'b1;
      step(3);
      bus_ack = 1'b1; step(); bus_ack = 1'b0;
      chk_tmo("ack_wins", 1'b0, 1'b0, 3'd0);
      step(4);
      chk_tmo("tmo_refire", 1'b1, 1'b1, 3'd2);
      sys_rst = 1'b1;
      #2;
      chk_gnt("async_rst_gnt", 7'h01);
      chk_tmo("async_rst_tmo", 1'b0, 1'b0, 3'd0);
      bus_stb = 1'b0;
      req = 7'h00;
      step();
      sys_rst = 1'b0;
      step();
      chk_gnt("post_rst_gnt", 7'h01);
   endtask

   task automatic test_prio();
      req = 7'h08; step(); chk_gnt("prio_to3", 7'h08);
      req = 7'h1D; step(); chk_gnt("prio_hold3", 7'h08);
      req = 7'h15; step();
`ifdef CONBUS_ARB_PRIO0_EN
      chk_gnt("prio_handover", 7'h01);
`else
      chk_gnt("prio_handover", 7'h10);
`endif
      req = 7'h00; step();
   endtask

   initial begin
      test_reset();
      test_rotate();
      test_wrap();
      test_back_to_back();
      test_timeout();
      test_ack_wins();
      test_prio();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/conbus_arb_wdt.md
Name: conbus_arb_wdt

Overview:
- Round-robin grant controller for the shared Wishbone conbus datapath: 7 masters, one shared bus.
- Holds the grant for a master's whole cycle (cyc) and hands it over only when that master drops its request.
- Adds a bus watchdog: a strobe left unacknowledged too long is terminated with a forced ack, so a dead or unmapped slave cannot hang the system.
- Drives the one-hot gnt vector used by the conbus master mux and ack gating; tmo_ack is ORed into the shared ack path by the integrator.

Parameters:
- N_MASTERS, 7, number of requesters (width of req/gnt), 2..8.
- TMO_W, 8, width of the watchdog counter.
- TMO_CYCLES, 255, stall cycles before forced termination, 1..2^TMO_W-1.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst  in  1  asynchronous active-high reset.
- req  in  N_MASTERS  per-master cyc request.
- bus_stb  in  1  cyc&stb of the currently granted master (shared bus).
- bus_ack  in  1  OR of slave acks on the shared bus.
- tmo_clr  in  1  clears sticky timeout status.
- gnt  out  N_MASTERS  one-hot grant, registered.
- tmo_ack  out  1  forced single-cycle ack to the granted master.
- tmo_err  out  1  sticky: a timeout has occurred since last clear.
- tmo_master  out  3  index of the master granted at the last timeout.

Behaviour:
- Interface: one clock, sys_clk; reset is asynchronous and active-high, sys_rst.
- Reset, applied immediately, mid-transfer included: gnt=1 (master 0), tmo_ack=0, tmo_err=0, tmo_master=0, watchdog count=0.
- gnt is always exactly one-hot and never all-zero.
- Arbitration, evaluated every cycle:
  - req[cur]=1: hold grant.
  - req[cur]=0: select the first requesting master in order cur+1, cur+2, ... with wrap-around, excluding cur.
  - No other request: hold cur (parked).
- Grant latency: new gnt is visible the cycle after req[cur] is sampled low. No dead cycle between owners.
- Master asserting req while already owner (re-request after a 1-cycle drop): rotation still applies if another master was requesting in the drop cycle.
- Simultaneous requests: strictly round-robin from cur; no fixed priority in the base build.
- Watchdog count:
  - Clears when bus_stb=0, bus_ack=1, tmo_ack=1, or gnt changes.
  - Otherwise increments, saturating at TMO_CYCLES.
- Timeout trigger: when count==TMO_CYCLES-1 and bus_stb=1 and bus_ack=0:
  - next cycle tmo_ack=1 for exactly one cycle;
  - tmo_err set;
  - tmo_master = index of gnt.
- bus_ack=1 in the trigger cycle: real ack wins; no tmo_ack, no error.
- tmo_ack is never asserted on two consecutive cycles.
- tmo_clr and a new timeout in the same cycle: set wins (tmo_err stays 1, tmo_master updated).
- tmo_clr alone clears tmo_err and tmo_master to 0 next cycle.

Optional Feature:
- Macro CONBUS_ARB_PRIO0_EN.
- Defined: on handover, master 0 is granted first if req[0]=1, regardless of rotation position; other masters remain round-robin among themselves. An owner's held grant is never preempted.
- Not defined: pure round-robin as above.

Test Plan:
- Reset with req=7'h00 -> gnt=7'h01; all tmo outputs 0; hold 10 cycles -> gnt stays 7'h01.
- gnt=7'h01, req=7'h0C, then req[0] drops -> next cycle gnt=7'h04. req[2] drops -> gnt=7'h08. req[3] drops with req=0 -> gnt parks at 7'h08.
- gnt=7'h40, req=7'h41, req[6] drops -> gnt wraps to 7'h01 (wrap-around).
- TMO_CYCLES=4, gnt=7'h04, bus_stb=1, bus_ack=0 held -> tmo_ack high exactly on 5th cycle after stb rise, one cycle; tmo_err=1; tmo_master=2. Pulse tmo_clr -> tmo_err=0, tmo_master=0.
- TMO_CYCLES=4, bus_ack=1 in the trigger cycle -> no tmo_ack, tmo_err stays 0. Assert sys_rst mid-stall -> outputs return to reset values asynchronously.
- With CONBUS_ARB_PRIO0_EN: gnt=7'h08, req=7'h15 as req[3] drops -> gnt=7'h01. Without the macro, same stimulus -> gnt=7'h10.
